// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer driving the tuning word of a DDS phase accumulator.
// Latency: ftw/ftw_valid/phase_rst register one clock after the start or dwell-expiry edge.
// Backpressure: none; stop aborts on the next edge and start is ignored while a sweep is active.
module dds_sweep_ctrl #(
  parameter int FTW_W   = 24,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [FTW_W-1:0]   f_start,
  input  logic [FTW_W-1:0]   f_stop,
  input  logic [FTW_W-1:0]   f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FTW_W-1:0]   ftw,
  output logic               ftw_valid,
  output logic               phase_rst,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // DWELL: holding ftw, more than one dwell cycle left.
  // STEP:  last dwell cycle of a non-final ftw; the next edge advances ftw.
  // FINAL: holding ftw == f_stop; expiry ends or restarts the sweep.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2,
    FINAL = 2'd3
  } state_t;

  state_t             state;
  logic               cont_l;
  logic [FTW_W-1:0]   f_start_l;
  logic [FTW_W-1:0]   f_stop_l;
  logic [FTW_W-1:0]   step_l;
  logic [DWELL_W-1:0] dwell_l;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_inc;
  logic [FTW_W:0]     nxt;

  // One extra bit on the sum so a step past the top of the range is seen, not wrapped.
  assign nxt     = {1'b0, ftw} + {1'b0, step_l};
  assign cnt_inc = cnt + {{(DWELL_W-1){1'b0}}, 1'b1};

  // State to enter right after loading a new ftw: the end frequency goes to FINAL,
  // otherwise a zero dwell means the very first cycle is already the stepping cycle.
  function automatic state_t hold_state(input logic [FTW_W-1:0]   f,
                                        input logic [FTW_W-1:0]   f_end,
                                        input logic [DWELL_W-1:0] d);
    if (f == f_end)
      return FINAL;
    else if (d == '0)
      return STEP;
    else
      return DWELL;
  endfunction

  // Sweep sequencer: state, dwell counter, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cont_l    <= 1'b0;
      f_start_l <= '0;
      f_stop_l  <= '0;
      step_l    <= '0;
      dwell_l   <= '0;
      cnt       <= '0;
      ftw       <= '0;
      ftw_valid <= 1'b0;
      phase_rst <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ftw_valid <= 1'b0;
      phase_rst <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;

      if (state != IDLE && stop) begin
        // Abort: keep the current ftw, no done and no new word.
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              if (f_start > f_stop) begin
                err <= 1'b1;
              end else begin
                cont_l    <= cont;
                f_start_l <= f_start;
                f_stop_l  <= f_stop;
                step_l    <= (f_step == '0) ? {{(FTW_W-1){1'b0}}, 1'b1} : f_step;
                dwell_l   <= dwell;
                ftw       <= f_start;
                ftw_valid <= 1'b1;
                phase_rst <= 1'b1;
                busy      <= 1'b1;
                cnt       <= '0;
                state     <= hold_state(f_start, f_stop, dwell);
              end
            end
          end

          DWELL: begin
            cnt <= cnt_inc;
            if (cnt_inc == dwell_l)
              state <= STEP;
          end

          STEP: begin
            cnt       <= '0;
            ftw_valid <= 1'b1;
            if (nxt >= {1'b0, f_stop_l}) begin
              ftw   <= f_stop_l;
              state <= FINAL;
            end else begin
              ftw   <= nxt[FTW_W-1:0];
              state <= (dwell_l == '0) ? STEP : DWELL;
            end
          end

          FINAL: begin
            if (cnt != dwell_l) begin
              cnt <= cnt_inc;
            end else if (cont_l) begin
              // Sawtooth: jump back to the start frequency and re-clear the accumulator.
              cnt       <= '0;
              ftw       <= f_start_l;
              ftw_valid <= 1'b1;
              phase_rst <= 1'b1;
              state     <= hold_state(f_start_l, f_stop_l, dwell_l);
            end else begin
              cnt   <= '0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter FTW_W, default 24, meaning the width of the frequency tuning word supplied to the DDS phase accumulator.
REQ-002 SHALL have parameter DWELL_W, default 16, meaning the width of the dwell-count field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1 bit: abort request.
REQ-007 SHALL have port cont, input, 1 bit: 0 = single sweep, 1 = continuous sawtooth.
REQ-008 SHALL have ports f_start, f_stop, f_step, input, FTW_W bits each: the sweep bounds and increment.
REQ-009 SHALL have port dwell, input, DWELL_W bits: each frequency is held for dwell+1 clocks.
REQ-010 SHALL have port ftw, output, FTW_W bits: the registered tuning word driven to the DDS.
REQ-011 SHALL have port ftw_valid, output, 1 bit: 1-cycle pulse in the cycle ftw takes a new value.
REQ-012 SHALL have port phase_rst, output, 1 bit: 1-cycle pulse requesting a DDS accumulator clear at each sweep (re)start.
REQ-013 SHALL have ports busy, done and err, output, 1 bit each: busy = sweep active; done = 1-cycle end pulse; err = 1-cycle config-reject pulse.

Function
REQ-014 SHALL implement the states IDLE, DWELL, STEP and FINAL.
REQ-015 IDLE, start=1, stop=0, f_start<=f_stop: latch cont/f_start/f_stop/f_step/dwell; next edge gives ftw=f_start, ftw_valid=1, phase_rst=1, busy=1, state DWELL.
REQ-016 IDLE, start=1, f_start>f_stop: assert err for 1 cycle, remain IDLE, leave ftw unchanged.
REQ-017 In IDLE, start and stop together: stop wins; start ignored, no err.
REQ-018 The dwell counter SHALL reload to 0 on every ftw update and expire after dwell+1 cycles at that ftw (dwell=0 gives an update every cycle).
REQ-019 Dwell expiry with ftw<f_stop: STEP computes nxt=ftw+f_step in FTW_W+1 bits; nxt>=f_stop gives ftw=f_stop, state FINAL; otherwise ftw=nxt, state DWELL; ftw_valid=1 in both cases.
REQ-020 f_step=0 SHALL be treated as a step of 1.
REQ-021 f_start==f_stop: go directly to FINAL at f_start.
REQ-022 FINAL dwell expiry, cont=0: done=1 for 1 cycle, busy=0, state IDLE, ftw held at f_stop.
REQ-023 FINAL dwell expiry, cont=1: ftw=f_start, ftw_valid=1, phase_rst=1, busy stays 1, state DWELL; done not asserted.
REQ-024 stop=1 in any busy state: next edge gives state IDLE, busy=0, ftw held, no done, no ftw_valid.
REQ-025 start asserted while busy SHALL be ignored; config inputs SHALL be ignored while busy.
REQ-026 ftw SHALL never wrap past 2^FTW_W-1 and never exceed the latched f_stop.

Reset
REQ-027 rst=0 at a clock edge SHALL force state IDLE, ftw=0, ftw_valid=0, phase_rst=0, busy=0, done=0, err=0 and dwell counter=0, regardless of state.
REQ-028 Reset mid-sweep SHALL abort with no done pulse; the first start after rst=1 behaves per REQ-015.

Verification
REQ-029 f_start=100, f_step=50, f_stop=300, dwell=2, cont=0 -> ftw 100,150,200,250,300, each held 3 clocks; 5 ftw_valid pulses; done 3 clocks after ftw=300; busy=0.
REQ-030 f_start=0, f_step=7, f_stop=20, dwell=0 -> ftw 0,7,14,20 on consecutive clocks, then done; clamp at f_stop.
REQ-031 FTW_W=24, f_start=0xFFFFF0, f_step=0x20, f_stop=0xFFFFFF -> ftw 0xFFFFF0 then 0xFFFFFF, no wrap to 0x000010.
REQ-032 cont=1, f_start=10, f_step=10, f_stop=30, dwell=1 -> 10,20,30,10,20,... with phase_rst at each 10, never done; stop -> busy=0 next clock.
REQ-033 start with f_start=500, f_stop=400 -> err pulse, busy stays 0; start while busy ignored; rst=0 mid-sweep -> all outputs 0 next edge.
